// File: rtl/frame_seq_ctrl.sv
// frame_seq_ctrl: plays a host-programmed table of frames into one frame_gen.
// Each entry is preceded by a two-cycle LOAD. The entry then plays for WIDTH
// cycles with ena high, repeats rep_cnt times, and is followed by gap_len idle
// cycles after every play. The list can optionally loop forever.
module frame_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic             stop,
  input  logic [AW-1:0]    last_idx,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [CNT_W-1:0] gap_len,
  input  logic             loop,
  output logic [WIDTH-1:0] frame_out,
  output logic             ena_out,
  output logic             rotate_out,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    cur_idx
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_NEXT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_table [DEPTH];
  logic [WIDTH-1:0] r_frame;
  logic             r_ena;
  logic             r_busy;
  logic             r_done;
  logic [AW-1:0]    r_cur_idx;
  logic             r_load_cnt;
  logic [PW-1:0]    r_play_cnt;
  logic [CNT_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_rep_cnt;
  logic [AW-1:0]    r_last_idx;
  logic [CNT_W-1:0] r_rep_cfg;
  logic [CNT_W-1:0] r_gap_cfg;
  logic             r_loop;

  state_t           w_next_state;
  logic [WIDTH-1:0] w_frame;
  logic             w_done;
  logic [AW-1:0]    w_cur_idx;
  logic             w_load_cnt;
  logic [PW-1:0]    w_play_cnt;
  logic [CNT_W-1:0] w_gap_cnt;
  logic [CNT_W-1:0] w_rep_cnt;
  logic             w_latch_cfg;
  logic [CNT_W-1:0] w_rep_cfg_in;

  // A repeat count of zero means one play.
  assign w_rep_cfg_in = (rep_cnt == '0) ? CNT_W'(1) : rep_cnt;

  // Frame table, written by the host in any state.
  // NOTE: the table is storage only and is deliberately left out of reset, so it maps onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_table[wr_addr] <= wr_data;
    end
  end

  // Next-state and next-register decode for the sequencer.
  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    w_next_state = r_state;
    w_frame      = r_frame;
    w_done       = 1'b0;
    w_cur_idx    = r_cur_idx;
    w_load_cnt   = r_load_cnt;
    w_play_cnt   = r_play_cnt;
    w_gap_cnt    = r_gap_cnt;
    w_rep_cnt    = r_rep_cnt;
    w_latch_cfg  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_next_state = S_LOAD;
          w_cur_idx    = '0;
          w_rep_cnt    = '0;
          w_load_cnt   = 1'b0;
          w_latch_cfg  = 1'b1;
        end
      end
      S_LOAD: begin
        if (r_load_cnt) begin
          w_next_state = S_PLAY;
          w_play_cnt   = '0;
        end else begin
          w_load_cnt = 1'b1;
        end
      end
      S_PLAY: begin
        if (r_play_cnt == PW'(WIDTH - 1)) begin
          w_rep_cnt = r_rep_cnt + CNT_W'(1);
          w_gap_cnt = '0;
          w_next_state = (r_gap_cfg == '0) ? S_NEXT : S_GAP;
        end else begin
          w_play_cnt = r_play_cnt + PW'(1);
        end
      end
      S_GAP: begin
        // Compare before incrementing so a full-scale gap never wraps.
        if (r_gap_cnt == r_gap_cfg - CNT_W'(1)) begin
          w_next_state = S_NEXT;
        end else begin
          w_gap_cnt = r_gap_cnt + CNT_W'(1);
        end
      end
      S_NEXT: begin
        w_load_cnt = 1'b0;
        if (r_rep_cnt < r_rep_cfg) begin
          w_next_state = S_LOAD;
        end else if (r_cur_idx < r_last_idx) begin
          w_cur_idx    = r_cur_idx + AW'(1);
          w_rep_cnt    = '0;
          w_next_state = S_LOAD;
        end else if (r_loop) begin
          w_cur_idx    = '0;
          w_rep_cnt    = '0;
          w_next_state = S_LOAD;
        end else begin
          w_next_state = S_IDLE;
          w_done       = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase

    // Abort from any active state: back to IDLE, no done, frame held.
    if (r_state != S_IDLE && stop) begin
      w_next_state = S_IDLE;
      w_done       = 1'b0;
      w_cur_idx    = r_cur_idx;
    end

    // Capture the entry's frame on every entry into LOAD.
    if (w_next_state == S_LOAD && r_state != S_LOAD) begin
      w_frame = r_table[w_cur_idx];
    end
  end

  // State, counters, latched configuration and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_frame    <= '0;
      r_ena      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cur_idx  <= '0;
      r_load_cnt <= 1'b0;
      r_play_cnt <= '0;
      r_gap_cnt  <= '0;
      r_rep_cnt  <= '0;
      r_last_idx <= '0;
      r_rep_cfg  <= '0;
      r_gap_cfg  <= '0;
      r_loop     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_frame    <= w_frame;
      r_ena      <= (w_next_state == S_PLAY);
      r_busy     <= (w_next_state != S_IDLE);
      r_done     <= w_done;
      r_cur_idx  <= w_cur_idx;
      r_load_cnt <= w_load_cnt;
      r_play_cnt <= w_play_cnt;
      r_gap_cnt  <= w_gap_cnt;
      r_rep_cnt  <= w_rep_cnt;
      if (w_latch_cfg) begin
        r_last_idx <= last_idx;
        r_rep_cfg  <= w_rep_cfg_in;
        r_gap_cfg  <= gap_len;
        r_loop     <= loop;
      end
    end
  end

  assign frame_out  = r_frame;
  assign ena_out    = r_ena;
  assign rotate_out = 1'b0;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cur_idx    = r_cur_idx;

endmodule

// File: doc/frame_seq_ctrl.md
Name: frame_seq_ctrl

Overview:
- Sequencer that drives one frame_gen instance (frame/ena/rotate inputs) to play a programmed list of frames.
- Holds a small frame table written by the host/PS side.
- On start, plays entries 0..last_idx in order. Each entry is repeated a configured number of times, with idle gap cycles between plays.
- Optionally loops forever. Sits between the register interface and frame_gen in the pulse-pattern path.

Parameters:
- WIDTH, 32, frame width; must equal the driven frame_gen WIDTH.
- DEPTH, 4, number of frame-table entries (power of two, >=2).
- AW, 2, table address width = log2(DEPTH).
- CNT_W, 16, width of the repeat and gap counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write address
- wr_data  in  WIDTH  table write data
- start  in  1  level; sampled only in IDLE
- stop  in  1  abort request, any state
- last_idx  in  AW  index of the final entry to play
- rep_cnt  in  CNT_W  plays per entry; 0 is treated as 1
- gap_len  in  CNT_W  idle cycles after each play
- loop  in  1  restart at entry 0 after last_idx instead of finishing
- frame_out  out  WIDTH  to frame_gen.frame
- ena_out  out  1  to frame_gen.ena
- rotate_out  out  1  to frame_gen.rotate; constant 0 (one-shot mode)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at normal completion
- cur_idx  out  AW  entry currently loaded/playing

Behaviour:
- Reset (async): state=IDLE, frame_out=0, ena_out=0, rotate_out=0, busy=0, done=0, cur_idx=0, all counters 0. Table contents are undefined after reset; the table itself is not reset.
- All outputs are registered.
- Table write: on a clk edge with wr_en=1, table[wr_addr] <= wr_data. Writes are allowed in any state. frame_out is captured only on entry to LOAD, so a write to the playing entry affects the next LOAD of that entry only.
- Config latch: last_idx, rep_cnt (0 mapped to 1), gap_len and loop are latched when leaving IDLE. Changes during a run are ignored.
- States:
  - IDLE: ena_out=0. If start=1 and stop=0 -> LOAD with cur_idx=0 and repeat counter=0; frame_out <= table[0].
  - LOAD: exactly 2 cycles, ena_out=0. Gives frame_gen's 1-cycle ena synchroniser time to reload. Then -> PLAY.
  - PLAY: exactly WIDTH cycles, ena_out=1. frame_gen emits bit0..bit(WIDTH-1), starting one cycle after ena_out rises. Then increment the repeat counter -> GAP, or -> NEXT if gap_len=0.
  - GAP: gap_len cycles, ena_out=0. Then -> NEXT.
  - NEXT: 1 cycle, pure decision, ena_out=0:
    - If repeat counter < rep_cnt: -> LOAD, same cur_idx.
    - Else if cur_idx < last_idx: cur_idx++, repeat counter=0 -> LOAD.
    - Else if loop=1: cur_idx=0, repeat counter=0 -> LOAD.
    - Else -> IDLE with done=1 for that cycle.
  - LOAD re-captures frame_out <= table[cur_idx] on every entry.
- Period per play = 2 + WIDTH + gap_len + 1 cycles. Total for a non-loop run = (last_idx+1) * rep_cnt_eff * that period.
- stop=1 in any non-IDLE state: next state IDLE, ena_out=0, busy=0, no done pulse. frame_out holds its last value.
- start and stop high together in IDLE: stop wins, and the block stays IDLE.
- start held high after completion re-triggers a new run from the IDLE cycle that follows done.
- last_idx > DEPTH-1 cannot occur (AW bits). last_idx=0 plays entry 0 only.
- Counter wrap: rep_cnt = 2^CNT_W-1 and gap_len = 2^CNT_W-1 must work without overflow. Compare before increment.
- Async reset mid-run: immediate return to the reset values above. ena_out drops asynchronously.

Test Plan:
- (Bench WIDTH=8, DEPTH=4, frame_gen instantiated downstream.)
- Write table[0]=0xA5. Set last_idx=0, rep_cnt=1, gap_len=0, loop=0; pulse start -> ena_out low 2 cycles then high 8 cycles. frame_gen pulse = 1,0,1,0,0,1,0,1. done pulses exactly 11 cycles after leaving IDLE; busy=0 afterwards.
- Table 0x01, 0x80, 0xFF. Set last_idx=2, rep_cnt=2, gap_len=3 -> cur_idx sequence 0,0,1,1,2,2. Each play lasts 14 cycles; done at cycle 84.
- Set rep_cnt=0 -> behaves as rep_cnt=1, with identical timing to scenario 1.
- Set loop=1, last_idx=1, and run 5 plays; assert stop mid-PLAY -> ena_out=0 next cycle, busy=0, done never pulses. Then assert start and stop together -> the block stays IDLE.
- During PLAY of entry 1, write a new value to table[1] -> the current play is unchanged and the next play of entry 1 uses the new value.
- Assert rst asynchronously during GAP -> all outputs return to 0 immediately. start after reset release plays normally from entry 0.
